// File: rtl/parity_pkg.sv
// Shared definitions for the parity generator / checker path.
// Holds the receiver FSM state type, the serial line levels and the
// reference parity function used by parity_calc on both sides.
package parity_pkg;

  // Receiver frame states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Serial line level while idle and the level of a good stop bit
  localparam logic IDLE_LEVEL = 1'b1;
  localparam logic STOP_LEVEL = 1'b1;

  // Widest data word the parity function accepts
  localparam int MAX_DATA_W = 16;

  // Parity bit for a data word: XOR of all bits, inverted for odd parity.
  // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic parity_of(input logic [MAX_DATA_W-1:0] data,
                                     input logic                  odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/parity_calc.sv
// Combinational parity of a WIDTH-bit word with an odd-parity select.
// Used by the generator and by the checker so both agree on one definition.
module parity_calc
  import parity_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             odd_i,
  output logic             par_o
);

  assign par_o = parity_of(MAX_DATA_W'(data_i), odd_i);

endmodule

// File: rtl/parity_check_rx.sv
// Serial receiver / checker for parity-protected frames:
// start bit (0), DATA_W data bits MSB first, parity bit, stop bit (1).
// Reports the received word together with parity and framing errors.
// Optional build macro PARITY_ERR_CNT_EN adds a saturating 8-bit error
// counter (err_cnt) with a synchronous clear input (err_cnt_clr).
module parity_check_rx
  import parity_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              sin,
  output logic [DATA_W-1:0] data_out,
  output logic              frame_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
`ifdef PARITY_ERR_CNT_EN
  ,
  input  logic              err_cnt_clr,
  output logic [7:0]        err_cnt
`endif
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                run_par_q, run_par_d;
  logic                mismatch_q, mismatch_d;
  logic                frame_valid_q, frame_valid_d;
  logic                parity_err_q, parity_err_d;
  logic                frame_err_q, frame_err_d;
  logic                busy_q, busy_d;
  logic                step_par_s;

  // One serial parity step: running parity XOR the incoming data bit
  parity_calc #(.WIDTH(2)) u_step_par (
    .data_i ({run_par_q, sin}),
    .odd_i  (1'b0),
    .par_o  (step_par_s)
  );

  // Next-state and next-output logic; everything advances only on bit_en
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    data_d        = data_q;
    cnt_d         = cnt_q;
    run_par_d     = run_par_q;
    mismatch_d    = mismatch_q;
    frame_valid_d = 1'b0;
    parity_err_d  = parity_err_q;
    frame_err_d   = frame_err_q;
    if (bit_en) begin
      case (state_q)
        IDLE: begin
          if (sin != IDLE_LEVEL) begin
            state_d   = DATA;
            cnt_d     = '0;
            run_par_d = ODD_PARITY;
          end else begin
            state_d = IDLE;
          end
        end
        DATA: begin
          // Left shift; the truncation drops the oldest bit beyond DATA_W
          shift_d   = DATA_W'({shift_q, sin});
          run_par_d = step_par_s;
          cnt_d     = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = PARITY;
          end else begin
            state_d = DATA;
          end
        end
        PARITY: begin
          mismatch_d = sin ^ run_par_q;
          state_d    = STOP;
        end
        STOP: begin
          // A bad stop bit still reports the word and its parity result
          data_d        = shift_q;
          parity_err_d  = mismatch_q;
          frame_err_d   = (sin != STOP_LEVEL);
          frame_valid_d = 1'b1;
          state_d       = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset aborts any frame in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      data_q        <= '0;
      cnt_q         <= '0;
      run_par_q     <= 1'b0;
      mismatch_q    <= 1'b0;
      frame_valid_q <= 1'b0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      data_q        <= data_d;
      cnt_q         <= cnt_d;
      run_par_q     <= run_par_d;
      mismatch_q    <= mismatch_d;
      frame_valid_q <= frame_valid_d;
      parity_err_q  <= parity_err_d;
      frame_err_q   <= frame_err_d;
      busy_q        <= busy_d;
    end
  end

  assign data_out    = data_q;
  assign frame_valid = frame_valid_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign busy        = busy_q;

`ifdef PARITY_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Count reported bad frames, saturating; clear has priority
  always_comb begin
    if (err_cnt_clr) begin
      err_cnt_d = 8'h00;
    end else if (frame_valid_q && (parity_err_q || frame_err_q) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'h01;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Error counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'h00;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_parity_check_rx.sv
// Directed bench for parity_check_rx: an even-parity and an odd-parity
// instance receive the same serial stream; a frame-level model predicts
// each completed frame and a monitor compares outputs every cycle.
module tb_parity_check_rx;
  import parity_pkg::*;

  localparam int W = 4;

  logic         clk    = 1'b0;
  logic         rst_n  = 1'b0;
  logic         bit_en = 1'b0;
  logic         sin    = 1'b1;
  logic [W-1:0] dout_e, dout_o;
  logic         fv_e, fv_o, pe_e, pe_o, fe_e, fe_o, busy_e, busy_o;
  logic         calc_e_s, calc_o_s;
`ifdef PARITY_ERR_CNT_EN
  logic [7:0]   ec_e, ec_o;
  int           m_ec_e = 0;
  int           m_ec_o = 0;
`endif

  always #5 clk = ~clk;

  parity_check_rx #(.DATA_W(W), .ODD_PARITY(1'b0)) u_even (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .sin(sin),
    .data_out(dout_e), .frame_valid(fv_e), .parity_err(pe_e),
    .frame_err(fe_e), .busy(busy_e)
`ifdef PARITY_ERR_CNT_EN
    , .err_cnt_clr(1'b0), .err_cnt(ec_e)
`endif
  );

  parity_check_rx #(.DATA_W(W), .ODD_PARITY(1'b1)) u_odd (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .sin(sin),
    .data_out(dout_o), .frame_valid(fv_o), .parity_err(pe_o),
    .frame_err(fe_o), .busy(busy_o)
`ifdef PARITY_ERR_CNT_EN
    , .err_cnt_clr(1'b0), .err_cnt(ec_o)
`endif
  );

  // Reference parity of the word each receiver reports
  parity_calc #(.WIDTH(W)) u_ref_e (.data_i(dout_e), .odd_i(1'b0), .par_o(calc_e_s));
  parity_calc #(.WIDTH(W)) u_ref_o (.data_i(dout_o), .odd_i(1'b1), .par_o(calc_o_s));

  typedef struct {
    logic [W-1:0] data;
    logic         pbit;
    logic         stop;
  } frame_t;

  frame_t       exp_q[$];
  int           total = 0;
  int           bad = 0;
  int           fv_count = 0;
  bit           in_frame = 1'b0;
  bit           prev_fv = 1'b0;
  logic [W-1:0] last_data = '0;
  logic         last_pe_e = 1'b0;
  logic         last_pe_o = 1'b0;
  logic         last_fe = 1'b0;
  logic         last_pbit = 1'b0;

  // Parity error from counting ones: the correct bit makes the total (data+parity)
  // even for even parity, odd for odd parity
  function automatic logic model_perr(input logic [W-1:0] d, input logic p, input logic odd);
    int ones;
    ones = $countones(d) + (p ? 1 : 0);
    return ((ones % 2) == 1) != odd;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one bit on a bit_en strobe, then hold bit_en low for the rest of the period
  task automatic sample(input logic b, input int period);
    sin    = b;
    bit_en = 1'b1;
    @(negedge clk);
    for (int i = 1; i < period; i++) begin
      bit_en = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    sin    = 1'b1;
    bit_en = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic p, input logic stop, input int period);
    frame_t f;
    f.data = d;
    f.pbit = p;
    f.stop = stop;
    exp_q.push_back(f);
    sample(1'b0, period);
    in_frame = 1'b1;
    for (int i = W - 1; i >= 0; i--) sample(d[i], period);
    sample(p, period);
    sample(stop, period);
  endtask

  task automatic do_reset;
    @(negedge clk);
    #2 rst_n = 1'b0;
    bit_en = 1'b0;
    sin    = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Per-cycle compare of both receivers against the frame model
  always @(negedge clk) begin
    frame_t e;
    if (!rst_n) begin
      chk("rst_data", {dout_e, dout_o}, '0);
      chk("rst_flags", {fv_e, fv_o, pe_e, pe_o, fe_e, fe_o, busy_e, busy_o}, '0);
      last_data = '0; last_pe_e = 1'b0; last_pe_o = 1'b0; last_fe = 1'b0;
      in_frame  = 1'b0;
      prev_fv   = 1'b0;
`ifdef PARITY_ERR_CNT_EN
      chk("rst_err_cnt", {ec_e, ec_o}, '0);
      m_ec_e = 0; m_ec_o = 0;
`endif
    end else begin
      chk("fv_same", fv_o, fv_e);
`ifdef PARITY_ERR_CNT_EN
      chk("err_cnt_e", ec_e, m_ec_e);
      chk("err_cnt_o", ec_o, m_ec_o);
`endif
      if (fv_e) begin
        chk("fv_back_to_back", prev_fv, 1'b0);
        chk("busy_at_valid", {busy_e, busy_o}, 2'b00);
        if (exp_q.size() == 0) begin
          chk("fv_unexpected", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          last_data = e.data;
          last_pbit = e.pbit;
          last_fe   = ~e.stop;
          last_pe_e = model_perr(e.data, e.pbit, 1'b0);
          last_pe_o = model_perr(e.data, e.pbit, 1'b1);
          fv_count++;
        end
        in_frame = 1'b0;
        total++;
        assert (pe_e == (calc_e_s ^ last_pbit) && pe_o == (calc_o_s ^ last_pbit))
        else begin
          bad++;
          $display("FAIL serial_vs_calc: pe_e=%0b pe_o=%0b calc_e=%0b calc_o=%0b pbit=%0b",
                   pe_e, pe_o, calc_e_s, calc_o_s, last_pbit);
        end
`ifdef PARITY_ERR_CNT_EN
        if (last_pe_e || last_fe) m_ec_e = (m_ec_e < 255) ? m_ec_e + 1 : 255;
        if (last_pe_o || last_fe) m_ec_o = (m_ec_o < 255) ? m_ec_o + 1 : 255;
`endif
      end
      chk("data_e", dout_e, last_data);
      chk("data_o", dout_o, last_data);
      chk("perr_e", pe_e, last_pe_e);
      chk("perr_o", pe_o, last_pe_o);
      chk("ferr", {fe_e, fe_o}, {last_fe, last_fe});
      if (in_frame && !fv_e) chk("busy_in_frame", {busy_e, busy_o}, 2'b11);
      prev_fv = fv_e;
    end
  end

  // Directed stimulus with hand-computed expectations
  initial begin
    repeat (2) @(negedge clk);
    chk("lit_reset", {dout_e, fv_e, pe_e, fe_e, busy_e}, 8'h00);
    rst_n = 1'b1;
    idle(2);

    // 1011 / p1 / stop1: even ok, odd parity error
    send_frame(4'b1011, 1'b1, 1'b1, 1);
    chk("lit1_fv", fv_e, 1'b1);
    chk("lit1_data", dout_e, 4'b1011);
    chk("lit1_err", {pe_e, fe_e, pe_o}, 3'b001);
    idle(2);

    // 1011 / p0: even parity error
    send_frame(4'b1011, 1'b0, 1'b1, 1);
    chk("lit2_data", dout_e, 4'b1011);
    chk("lit2_err", {pe_e, fe_e}, 2'b10);
    idle(2);

    // 0000 / p0 / stop0: framing error only on the even side
    send_frame(4'b0000, 1'b0, 1'b0, 1);
    chk("lit3_data", dout_e, 4'b0000);
    chk("lit3_err", {pe_e, fe_e}, 2'b01);
    idle(2);

    // bit_en every 4th cycle: 0110 / p0
    send_frame(4'b0110, 1'b0, 1'b1, 4);
    chk("lit4_data", dout_e, 4'b0110);
    chk("lit4_err", {pe_e, fe_e}, 2'b00);
    idle(2);

    // Aborted frame: start plus two data bits, then reset
    sample(1'b0, 1);
    sample(1'b1, 1);
    sample(1'b0, 1);
    chk("lit5_busy", busy_e, 1'b1);
    do_reset();
    chk("lit5_after_rst", {dout_e, pe_e, fe_e, busy_e}, 7'h00);
    idle(2);
    send_frame(4'b1001, 1'b0, 1'b1, 1);
    chk("lit6_data", dout_e, 4'b1001);
    chk("lit6_err", {pe_e, fe_e}, 2'b00);
    idle(2);

    // Back-to-back frames without an idle bit
    send_frame(4'b0001, 1'b1, 1'b1, 1);
    chk("lit7a_data", dout_e, 4'b0001);
    send_frame(4'b1110, 1'b1, 1'b1, 1);
    chk("lit7b_data", dout_e, 4'b1110);
    chk("lit7b_err", {pe_e, fe_e}, 2'b00);
    idle(2);

    // 1011 / p0 is clean for odd parity
    send_frame(4'b1011, 1'b0, 1'b1, 1);
    chk("lit8_odd", {dout_o, pe_o, fe_o}, {4'b1011, 2'b00});
    idle(3);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    chk("pending_frames", exp_q.size(), 0);
    chk("frame_count", fv_count, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
